mem_modport: RTL and testbench

- Single-port synchronous memory slave with a valid/ready request handshake, driven by a clocked bus-functional model and observed by a passive monitor.
- Each accepted request is either a write (store wdata_i at addr_i) or a read (return the stored word on rdata_o one cycle later).
- Serves as the storage endpoint of the memory verification environment.

---
 rtl/mem_modport.sv | 99 +++++++++
 tb/tb_mem_modport.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_modport.sv
// Single-port synchronous memory slave behind a valid/ready handshake.
// Every word is held in its own register so that reset can clear the whole
// array in one edge. Reads come back registered on rdata_o one cycle after
// the request is accepted. The slave never back-pressures once it is out of reset.
module mem_modport #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  wr_rd_i,
   input  logic [WIDTH-1:0]      wdata_i,
   output logic [WIDTH-1:0]      rdata_o,
   input  logic                  valid_i,
   output logic                  ready_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // ST_RESET covers the reset edges and the first cycle after them;
   // ST_READY is held until the next reset.
   typedef enum logic [0:0] {
      ST_RESET = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic              wr_en;
   logic              rd_en;
   logic [WIDTH-1:0]  rdata_reg;
   logic [WIDTH-1:0]  word_bus [DEPTH];

   // Handshake state register; reset forces the not-ready state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= ST_RESET;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: leave reset on the first clean edge, then stay ready
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RESET: state_next = ST_READY;
         ST_READY: state_next = ST_READY;
         default:  state_next = ST_RESET;
      endcase
   end

   // ready_o is decoded purely from the state flop, so no input reaches it
   assign ready_o = (state_reg == ST_READY);

   // Accept decode: one request per cycle, wr_rd_i picks write or read
   always_comb begin
      wr_en = 1'b0;
      rd_en = 1'b0;
      if (valid_i && ready_o) begin
         wr_en = wr_rd_i;
         rd_en = !wr_rd_i;
      end
   end

   // One register per word so the entire array can be cleared by reset
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
         logic [WIDTH-1:0] word_reg;
         logic             word_sel;

         assign word_sel = wr_en && (addr_i == ADDR_WIDTH'(gi));

         // Store incoming data when this word is the write target
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               word_reg <= '0;
            end else if (word_sel) begin
               word_reg <= wdata_i;
            end
         end

         assign word_bus[gi] = word_reg;
      end
   endgenerate

   // Registered read port; holds its value between accepted reads
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_reg <= '0;
      end else if (rd_en) begin
         rdata_reg <= word_bus[addr_i];
      end
   end

   assign rdata_o = rdata_reg;

endmodule

// File: tb/tb_mem_modport.sv
// Directed self-checking bench for mem_modport. Inputs are driven 1 time
// unit after each rising edge and outputs are checked at that same point.
module tb_mem_modport;

   localparam int WIDTH      = 16;
   localparam int ADDR_WIDTH = 5;
   localparam int DEPTH      = 32;

   logic                  clk_i;
   logic                  rst_i;
   logic [ADDR_WIDTH-1:0] addr_i;
   logic                  wr_rd_i;
   logic [WIDTH-1:0]      wdata_i;
   logic [WIDTH-1:0]      rdata_o;
   logic                  valid_i;
   logic                  ready_o;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [WIDTH-1:0] exp_mem [DEPTH];

   mem_modport #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .addr_i  (addr_i),
      .wr_rd_i (wr_rd_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o),
      .valid_i (valid_i),
      .ready_o (ready_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Drive a write for one cycle and record it in the expected image
   task automatic wr_word(input int a, input logic [WIDTH-1:0] d);
      valid_i = 1'b1;
      wr_rd_i = 1'b1;
      addr_i  = ADDR_WIDTH'(a);
      wdata_i = d;
      step();
      exp_mem[a] = d;
      valid_i = 1'b0;
   endtask

   // Drive a read for one cycle; the result is on rdata_o when this returns
   task automatic rd_word(input int a);
      valid_i = 1'b1;
      wr_rd_i = 1'b0;
      addr_i  = ADDR_WIDTH'(a);
      wdata_i = 16'hDEAD;
      step();
      valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i   = 1'b1;
      valid_i = 1'b1;
      wr_rd_i = 1'b1;
      addr_i  = 5'd9;
      wdata_i = 16'hFFFF;
      for (int c = 0; c < 2; c++) begin
         step();
         n_cmp++;
         if (ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready cyc%0d: got %b want 0", c, ready_o);
         end
         n_cmp++;
         if (rdata_o !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_rdata cyc%0d: got %h want 0000", c, rdata_o);
         end
      end
      rst_i   = 1'b0;
      valid_i = 1'b0;
      #1;
      n_cmp++;
      if (ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_before_edge: got %b want 0", ready_o);
      end
      step();
      n_cmp++;
      if (ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_release: got %b want 1", ready_o);
      end
      // Write presented during reset must have been dropped
      rd_word(9);
      n_cmp++;
      if (rdata_o !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_dropped_write: got %h want 0000", rdata_o);
      end
      $display("test_reset done");
   endtask

   task automatic test_single();
      wr_word(5, 16'hA5A5);
      n_cmp++;
      if (rdata_o !== 16'h0000) begin
         n_fail++;
         $display("FAIL write_keeps_rdata: got %h want 0000", rdata_o);
      end
      rd_word(5);
      n_cmp++;
      if (rdata_o !== 16'hA5A5) begin
         n_fail++;
         $display("FAIL single_rd: got %h want a5a5", rdata_o);
      end
      $display("test_single done");
   endtask

   task automatic test_sweep();
      for (int i = 0; i < DEPTH; i++) wr_word(i, 16'(i * 3));
      valid_i = 1'b1;
      wr_rd_i = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         if (i < DEPTH) addr_i = ADDR_WIDTH'(i);
         else valid_i = 1'b0;
         if (i > 0) begin
            n_cmp++;
            if (rdata_o !== 16'((i - 1) * 3)) begin
               n_fail++;
               $display("FAIL sweep_rd addr%0d: got %h want %h", i - 1, rdata_o, 16'((i - 1) * 3));
            end
         end
         if (i < DEPTH) step();
      end
      $display("test_sweep done");
   endtask

   task automatic test_wr_then_rd();
      wr_word(7, 16'h1234);
      rd_word(7);
      n_cmp++;
      if (rdata_o !== 16'h1234) begin
         n_fail++;
         $display("FAIL wr_rd_same: got %h want 1234", rdata_o);
      end
      wr_word(7, 16'hBEEF);
      rd_word(7);
      n_cmp++;
      if (rdata_o !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL overwrite: got %h want beef", rdata_o);
      end
      $display("test_wr_then_rd done");
   endtask

   task automatic test_idle();
      wr_word(5, 16'hA5A5);
      rd_word(5);
      n_cmp++;
      if (rdata_o !== 16'hA5A5) begin
         n_fail++;
         $display("FAIL idle_first_rd: got %h want a5a5", rdata_o);
      end
      for (int c = 0; c < 5; c++) begin
         valid_i = 1'b0;
         addr_i  = ADDR_WIDTH'($urandom_range(0, DEPTH - 1));
         wr_rd_i = 1'($urandom_range(0, 1));
         wdata_i = 16'($urandom);
         step();
         n_cmp++;
         if (rdata_o !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL idle_hold cyc%0d: got %h want a5a5", c, rdata_o);
         end
      end
      // Whole array must match the expected image after the idle cycles
      for (int i = 0; i < DEPTH; i++) begin
         rd_word(i);
         n_cmp++;
         if (rdata_o !== exp_mem[i]) begin
            n_fail++;
            $display("FAIL idle_mem addr%0d: got %h want %h", i, rdata_o, exp_mem[i]);
         end
      end
      $display("test_idle done");
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) wr_word(i, 16'(16'h1111 * (i + 1)));
      rst_i   = 1'b1;
      valid_i = 1'b1;
      wr_rd_i = 1'b1;
      addr_i  = 5'd2;
      wdata_i = 16'h7777;
      step();
      rst_i   = 1'b0;
      valid_i = 1'b0;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      n_cmp++;
      if (rdata_o !== 16'h0000) begin
         n_fail++;
         $display("FAIL midrst_rdata: got %h want 0000", rdata_o);
      end
      n_cmp++;
      if (ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_ready: got %b want 0", ready_o);
      end
      step();
      n_cmp++;
      if (ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_ready_back: got %b want 1", ready_o);
      end
      for (int i = 0; i < 4; i++) begin
         rd_word(i);
         n_cmp++;
         if (rdata_o !== 16'h0000) begin
            n_fail++;
            $display("FAIL midrst_rd addr%0d: got %h want 0000", i, rdata_o);
         end
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      rst_i   = 1'b1;
      valid_i = 1'b0;
      wr_rd_i = 1'b0;
      addr_i  = '0;
      wdata_i = '0;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      test_reset();
      test_single();
      test_sweep();
      test_wr_then_rd();
      test_idle();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
